fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Pipelined MIPS instruction-fetch stage: owns the PC, drives the instruction-memory address, and captures the fetched word into the IF/ID register.
- Directly upstream of the main decoder. op_d and funct_d feed the decoder and ALU decoder.
- Applies branch and jump redirects coming back from decode. Honours hazard-unit stall and flush requests.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word written into IF/ID on a flush (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall_f  in  1  hold pc_f
- stall_d  in  1  hold the IF/ID register
- flush_d  in  1  external bubble request into IF/ID
- pcsrc_d  in  1  taken branch resolved in decode
- pcbranch_d  in  32  branch target from decode; bits [1:0] ignored
- jump_d  in  1  jump decoded in decode (main decoder jump output)
- imem_addr  out  32  equals pc_f
- imem_rdata  in  32  instruction word; combinational read of imem_addr in the same cycle
- instr_d  out  32  IF/ID instruction
- pcplus4_d  out  32  IF/ID PC+4
- op_d  out  6  instr_d[31:26]
- funct_d  out  6  instr_d[5:0]
- valid_d  out  1  instr_d holds a real fetched instruction, not a bubble
- fetch_cnt  out  32  count of instructions loaded into IF/ID

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset). All state updates on the rising edge of clk.
- Reset values (on a clk edge with reset=1):
  - pc_f=RESET_PC
  - instr_d=NOP_INSTR, pcplus4_d=0, valid_d=0
  - fetch_cnt=0
- Reset overrides every other input. Reset mid-stall or mid-redirect discards all in-flight state.
- Internal signals:
  - pcplus4_f = pc_f + 4, mod 2^32 (0xFFFF_FFFC wraps to 0).
  - jta_d = {pcplus4_d[31:28], instr_d[25:0], 2'b00}.
  - redirect = jump_d | pcsrc_d.
- Next-PC priority: jump_d (jta_d) > pcsrc_d ({pcbranch_d[31:2],2'b00}) > pcplus4_f.
- PC register: if stall_f=1, pc_f holds and redirects that cycle are ignored. The hazard unit asserts stall_d with stall_f, so the branch or jump remains in decode and is re-presented. Otherwise pc_f <= next-PC.
- IF/ID register, priority order:
  1. reset.
  2. flush_d=1, or (redirect=1 and stall_d=0): instr_d <= NOP_INSTR, valid_d <= 0. pcplus4_d is loaded with pcplus4_f regardless.
  3. stall_d=1: hold all fields.
  4. Otherwise: instr_d <= imem_rdata, pcplus4_d <= pcplus4_f, valid_d <= 1.
- Latency:
  - An address presented on imem_addr in cycle N appears on instr_d in cycle N+1.
  - A redirect asserted in cycle N causes the target to be fetched in N+1. Exactly one bubble enters IF/ID.
- fetch_cnt increments by 1, wrapping mod 2^32, on each edge where case 4 (load) is taken. Flush cycles and stall cycles do not count.
- op_d and funct_d are purely combinational slices of instr_d, with no extra latency.
- Simultaneous events:
  - flush_d together with stall_d: the flush wins.
  - pcsrc_d together with jump_d: the jump wins.
  - stall_f=0 with stall_d=1: the PC advances and the fetched word is dropped. This combination is a legal hazard-unit choice only when the dropped word is refetched; the block does not check it.

Decomposition:
- Shared package mips_pkg holds:
  - OP_/FUNCT_ opcode constants (also used by the main decoder)
  - NOP_INSTR
  - RESET_PC default
  - word-alignment helper constant (2'b00)
- One natural sub-module, if_id_reg: the flush/stall/load register for instr_d, pcplus4_d and valid_d, with the priority order above.
- The PC register and next-PC mux stay in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles, imem returns addr-derived words → imem_addr 0,4,8,C; instr_d follows one cycle later; valid_d=1 from the 2nd cycle; fetch_cnt=3 after 4 edges.
- stall_f=stall_d=1 for 2 cycles at pc_f=8 → pc_f stays 8; instr_d and fetch_cnt unchanged; on release the sequence resumes at C.
- pcsrc_d=1, pcbranch_d=0x0000_0043 → next pc_f=0x40; instr_d=NOP with valid_d=0 for 1 cycle; then the word from 0x40.
- instr_d=0x0800_0010 (j 0x40), pcplus4_d=0x1000_0008, jump_d=1 and pcsrc_d=1 with pcbranch_d=0x200 → pc_f=0x1000_0040, not 0x200.
- flush_d=1 with stall_d=1 → instr_d=NOP, valid_d=0; pc_f advances when stall_f=0.
- Assert reset mid-redirect with pc_f=0x80 → next edge pc_f=RESET_PC, valid_d=0, fetch_cnt=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch stage and the decoders downstream.
// Holds the opcode/funct encodings, the bubble instruction, the default
// reset PC and the word-alignment constant used when forming PC targets.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // sll $0,$0,0 -- architecturally a no-op, used as the pipeline bubble
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Low two bits of every instruction address
  localparam logic [1:0] WORD_ALIGN = 2'b00;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures the fetched word and its PC+4.
// Priority: reset > bubble (flush, or redirect without stall) > stall > load.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   flush                 external bubble request
//   stall                 hold the register contents
//   redirect              a jump or taken branch is being applied this cycle
//   instr_in, pcplus4_in  word fetched this cycle and its PC+4
//   instr, pcplus4, valid registered IF/ID contents
//   load                  high in the cycle a real instruction is captured
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] instr_in,
  input  logic [31:0] pcplus4_in,
  output logic [31:0] instr,
  output logic [31:0] pcplus4,
  output logic        valid,
  output logic        load
);

  logic [31:0] instr_reg;
  logic [31:0] pcplus4_reg;
  logic        valid_reg;
  logic        bubble;

  // A redirect while decode is stalled must not bubble: the branch/jump is
  // still sitting in IF/ID and will be re-presented.
  assign bubble = flush | (redirect & ~stall);
  assign load   = ~bubble & ~stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_reg   <= NOP_WORD;
      pcplus4_reg <= 32'h0;
      valid_reg   <= 1'b0;
    end else if (bubble) begin
      instr_reg   <= NOP_WORD;
      pcplus4_reg <= pcplus4_in;
      valid_reg   <= 1'b0;
    end else if (load) begin
      instr_reg   <= instr_in;
      pcplus4_reg <= pcplus4_in;
      valid_reg   <= 1'b1;
    end
  end

  assign instr   = instr_reg;
  assign pcplus4 = pcplus4_reg;
  assign valid   = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection (jump >
// branch > sequential), instruction-memory address, and the IF/ID register.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   stall_f, stall_d, flush_d   hazard-unit controls
//   pcsrc_d, pcbranch_d         taken branch and its target from decode
//   jump_d                      jump decoded in decode
//   imem_addr / imem_rdata      instruction memory (combinational read)
//   instr_d, pcplus4_d, valid_d IF/ID contents
//   op_d, funct_d               opcode and funct fields of instr_d
//   fetch_cnt                   number of instructions loaded into IF/ID
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pcsrc_d,
  input  logic [31:0] pcbranch_d,
  input  logic        jump_d,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic [5:0]  op_d,
  output logic [5:0]  funct_d,
  output logic        valid_d,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pcplus4_f;
  logic [31:0] jta_d;
  logic [31:0] branch_tgt;
  logic        redirect;
  logic        load;
  logic [31:0] fetch_cnt_reg;

  assign pcplus4_f  = pc_reg + 32'd4;
  assign jta_d      = {pcplus4_d[31:28], instr_d[25:0], WORD_ALIGN};
  // Masking keeps the target word-aligned whatever decode sends.
  assign branch_tgt = pcbranch_d & 32'hFFFF_FFFC;
  assign redirect   = jump_d | pcsrc_d;

  always_comb begin
    pc_next = pcplus4_f;
    if (jump_d)       pc_next = jta_d;
    else if (pcsrc_d) pc_next = branch_tgt;
  end

  // A stalled PC ignores redirects; decode is stalled alongside and will
  // present the same branch/jump again once the stall clears.
  always_ff @(posedge clk) begin
    if (reset)         pc_reg <= RESET_PC;
    else if (!stall_f) pc_reg <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset)     fetch_cnt_reg <= 32'h0;
    else if (load) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
  end

  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush_d),
    .stall      (stall_d),
    .redirect   (redirect),
    .instr_in   (imem_rdata),
    .pcplus4_in (pcplus4_f),
    .instr      (instr_d),
    .pcplus4    (pcplus4_d),
    .valid      (valid_d),
    .load       (load)
  );

  assign imem_addr = pc_reg;
  assign op_d      = instr_d[31:26];
  assign funct_d   = instr_d[5:0];
  assign fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a directed table of cycles with hand-computed
// expectations, followed by randomized cycles checked against a cycle-level
// reference model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall_f, stall_d, flush_d, pcsrc_d, jump_d;
  logic [31:0] pcbranch_d;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_d, pcplus4_d, fetch_cnt;
  logic [5:0]  op_d, funct_d;
  logic        valid_d;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .pcsrc_d    (pcsrc_d),
    .pcbranch_d (pcbranch_d),
    .jump_d     (jump_d),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instr_d    (instr_d),
    .pcplus4_d  (pcplus4_d),
    .op_d       (op_d),
    .funct_d    (funct_d),
    .valid_d    (valid_d),
    .fetch_cnt  (fetch_cnt)
  );

  // Instruction memory contents: address-derived words, plus one jump
  // instruction (j 0x40) planted at 0x1000_0004.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000_0004) return 32'h0800_0010;
    return 32'hA5A5_0000 | {16'h0, a[15:0]};
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  typedef struct {
    string       name;
    logic        rst, sf, sd, fl, br, jp;
    logic [31:0] bt;
    logic [31:0] e_pc, e_instr, e_pp4;
    logic        e_v;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string n, input logic rst, input logic sf,
                              input logic sd, input logic fl, input logic br,
                              input logic jp, input logic [31:0] bt,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_pp4, input logic e_v,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.name = n; v.rst = rst; v.sf = sf; v.sd = sd; v.fl = fl; v.br = br; v.jp = jp;
    v.bt = bt; v.e_pc = e_pc; v.e_instr = e_instr; v.e_pp4 = e_pp4; v.e_v = e_v;
    v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", n, act, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic sf, input logic sd, input logic fl,
                       input logic br, input logic jp, input logic [31:0] bt);
    reset = rst; stall_f = sf; stall_d = sd; flush_d = fl;
    pcsrc_d = br; jump_d = jp; pcbranch_d = bt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string n, input logic [31:0] e_pc,
                           input logic [31:0] e_instr, input logic [31:0] e_pp4,
                           input logic e_v, input logic [31:0] e_cnt);
    logic [31:0] ei;
    ei = e_instr;
    chk({n, ".imem_addr"}, imem_addr, e_pc);
    chk({n, ".instr_d"},   instr_d,   ei);
    chk({n, ".pcplus4_d"}, pcplus4_d, e_pp4);
    chk({n, ".valid_d"},   {31'h0, valid_d}, {31'h0, e_v});
    chk({n, ".fetch_cnt"}, fetch_cnt, e_cnt);
    chk({n, ".op_funct"},  {20'h0, op_d, funct_d}, {20'h0, ei[31:26], ei[5:0]});
  endtask

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_v;

  initial begin
    reset = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0;
    pcsrc_d = 0; jump_d = 0; pcbranch_d = 0;

    //   name          rst sf sd fl br jp bt            pc            instr         pp4           v  cnt
    add("reset",        1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    add("run1",         0, 0, 0, 0, 0, 0, 32'h0,        32'h4,        32'hA5A50000, 32'h4,        1, 1);
    add("run2",         0, 0, 0, 0, 0, 0, 32'h0,        32'h8,        32'hA5A50004, 32'h8,        1, 2);
    add("stall1",       0, 1, 1, 0, 0, 0, 32'h0,        32'h8,        32'hA5A50004, 32'h8,        1, 2);
    add("stall2",       0, 1, 1, 0, 0, 0, 32'h0,        32'h8,        32'hA5A50004, 32'h8,        1, 2);
    add("resume1",      0, 0, 0, 0, 0, 0, 32'h0,        32'hC,        32'hA5A50008, 32'hC,        1, 3);
    add("resume2",      0, 0, 0, 0, 0, 0, 32'h0,        32'h10,       32'hA5A5000C, 32'h10,       1, 4);
    add("branch",       0, 0, 0, 0, 1, 0, 32'h43,       32'h40,       32'h0,        32'h14,       0, 4);
    add("br_tgt",       0, 0, 0, 0, 0, 0, 32'h0,        32'h44,       32'hA5A50040, 32'h44,       1, 5);
    add("br_far",       0, 0, 0, 0, 1, 0, 32'h10000004, 32'h10000004, 32'h0,       32'h48,       0, 5);
    add("fetch_j",      0, 0, 0, 0, 0, 0, 32'h0,        32'h10000008, 32'h08000010, 32'h10000008, 1, 6);
    add("jump_wins",    0, 0, 0, 0, 1, 1, 32'h200,      32'h10000040, 32'h0,       32'h1000000C, 0, 6);
    add("flush_stall",  0, 0, 1, 1, 0, 0, 32'h0,        32'h10000044, 32'h0,       32'h10000044, 0, 6);
    add("after_flush",  0, 0, 0, 0, 0, 0, 32'h0,        32'h10000048, 32'hA5A50044, 32'h10000048, 1, 7);
    add("br_80",        0, 0, 0, 0, 1, 0, 32'h80,       32'h80,       32'h0,        32'h1000004C, 0, 7);
    add("reset_redir",  1, 0, 0, 0, 1, 0, 32'h100,      32'h0,        32'h0,        32'h0,        0, 0);
    add("br_top",       0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0,       32'h4,        0, 0);
    add("wrap",         0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hA5A5FFFC, 32'h0,        1, 1);
    add("stall_redir",  0, 1, 1, 0, 1, 0, 32'h300,      32'h0,        32'hA5A5FFFC, 32'h0,        1, 1);
    add("drop_fetch",   0, 0, 1, 0, 0, 0, 32'h0,        32'h4,        32'hA5A5FFFC, 32'h0,        1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].br,
            vecs[i].jp, vecs[i].bt);
      check_all(vecs[i].name, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pp4,
                vecs[i].e_v, vecs[i].e_cnt);
      $display("vec %0d %s pc=%08h instr=%08h valid=%0b cnt=%0d",
               i, vecs[i].name, imem_addr, instr_d, valid_d, fetch_cnt);
    end

    // Randomized phase; the first cycle is a reset so the model starts in sync.
    m_pc = 0; m_instr = 0; m_pp4 = 0; m_v = 0; m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      logic rst, sf, sd, fl, br, jp;
      logic [31:0] bt, n_pc, n_instr, n_pp4, n_cnt, seq;
      logic n_v;
      rst = (i == 0) || ($urandom_range(0, 63) == 0);
      sf  = ($urandom_range(0, 7) == 0);
      sd  = sf || ($urandom_range(0, 15) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      br  = ($urandom_range(0, 5) == 0);
      jp  = ($urandom_range(0, 7) == 0);
      bt  = $urandom;

      // Next state from the fetch rules, computed from current model state.
      seq = m_pc + 32'd4;
      n_pc = m_pc; n_instr = m_instr; n_pp4 = m_pp4; n_v = m_v; n_cnt = m_cnt;
      if (rst) begin
        n_pc = 0; n_instr = 0; n_pp4 = 0; n_v = 0; n_cnt = 0;
      end else begin
        if (!sf) begin
          if (jp)      n_pc = {m_pp4[31:28], m_instr[25:0], 2'b00};
          else if (br) n_pc = (bt / 4) * 4;
          else         n_pc = seq;
        end
        if (fl || ((jp || br) && !sd)) begin
          n_instr = 0; n_v = 0; n_pp4 = seq;
        end else if (!sd) begin
          n_instr = mem_word(m_pc); n_pp4 = seq; n_v = 1; n_cnt = m_cnt + 1;
        end
      end

      apply(rst, sf, sd, fl, br, jp, bt);
      m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_v = n_v; m_cnt = n_cnt;
      check_all($sformatf("rand%0d", i), m_pc, m_instr, m_pp4, m_v, m_cnt);
      $display("rand %0d rst=%0b sf=%0b sd=%0b fl=%0b br=%0b jp=%0b pc=%08h instr=%08h valid=%0b cnt=%0d",
               i, rst, sf, sd, fl, br, jp, imem_addr, instr_d, valid_d, fetch_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
